// File: rtl/sw_debounce_if.sv
// Switch bus between the raw push-switch source and the debouncer.
// master: drives the raw levels and observes debounced results.
// slave : the debouncer itself.
interface sw_debounce_if;
  logic [2:0] sw_in;    // raw asynchronous levels, 1 = pressed
  logic [2:0] sw_out;   // debounced levels
  logic [2:0] sw_rise;  // one-cycle pulse on debounced 0->1

  modport master (output sw_in, input sw_out, input sw_rise);
  modport slave  (input sw_in, output sw_out, output sw_rise);
endinterface

// File: rtl/sw_debounce.sv
// Three-channel push-switch debouncer.
// Each channel: 2-flop synchronizer, then a 4-state qualify FSM that accepts
// a level change only after DEB_CNT consecutive agreeing samples. A rising
// edge of the debounced level produces a single-cycle sw_rise pulse.
module sw_debounce #(
  parameter int unsigned DEB_CNT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  sw_debounce_if.slave  bus
);

  typedef enum logic [1:0] {
    S_LO = 2'b00,
    W_HI = 2'b01,
    S_HI = 2'b10,
    W_LO = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CNT - 1);

  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_out_q;
  logic [2:0] w_out;

  // Two-flop synchronizer for the raw switch levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.sw_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    // Per-channel qualify FSM; any reversal while waiting aborts the change.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_LO;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_LO: begin
            if (r_sync2[g]) begin
              r_state <= W_HI;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_cnt   <= '0;
            end
          end
          W_HI: begin
            if (!r_sync2[g]) begin
              r_state <= S_LO;
              r_cnt   <= '0;
            end else if (r_cnt == LAST) begin
              r_state <= S_HI;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
            end
          end
          S_HI: begin
            if (!r_sync2[g]) begin
              r_state <= W_LO;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_cnt   <= '0;
            end
          end
          W_LO: begin
            if (r_sync2[g]) begin
              r_state <= S_HI;
              r_cnt   <= '0;
            end else if (r_cnt == LAST) begin
              r_state <= S_LO;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_LO;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    // Debounced level is a pure decode of the state register.
    assign w_out[g] = (r_state == S_HI) || (r_state == W_LO);
  end

  // Previous debounced level, used to form the rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q <= '0;
    end else begin
      r_out_q <= w_out;
    end
  end

  assign bus.sw_out  = w_out;
  assign bus.sw_rise = w_out & ~r_out_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce (DEB_CNT = 4).
module tb_sw_debounce;

  localparam int DEB = 4;

  logic clk;
  logic rst_n;

  sw_debounce_if ifc ();

  sw_debounce #(.DEB_CNT(DEB), .CNT_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a change is accepted once the synchronized level has
  // disagreed with the accepted level for DEB consecutive edges.
  logic [2:0] m_p1, m_p2, m_out, m_rise;
  int         m_run [3];

  function automatic void model_reset();
    m_p1 = '0; m_p2 = '0; m_out = '0; m_rise = '0;
    for (int c = 0; c < 3; c++) m_run[c] = 0;
  endfunction

  function automatic void model_step(input logic [2:0] v);
    logic [2:0] old;
    old = m_out;
    for (int c = 0; c < 3; c++) begin
      if (m_p2[c] != m_out[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB) begin
          m_out[c] = ~m_out[c];
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_rise = m_out & ~old;
    m_p2   = m_p1;
    m_p1   = v;
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(ifc.sw_in);
    #1;
  endtask

  task automatic cyc(input logic [2:0] v);
    @(negedge clk);
    ifc.sw_in = v;
    tick();
  endtask

  typedef struct {
    logic [2:0] vin;
    logic [2:0] vout;
    logic [2:0] vrise;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [2:0] i, input logic [2:0] o,
                              input logic [2:0] r, input int n);
    vec_t e;
    e.vin = i; e.vout = o; e.vrise = r;
    for (int k = 0; k < n; k++) tbl.push_back(e);
  endfunction

  initial begin
    int rise_cnt;
    int rise_idx;
    logic [2:0] v;

    rst_n     = 1'b0;
    ifc.sw_in = 3'b000;
    model_reset();
    #2;
    chk("reset_out", ifc.sw_out, 3'b000);
    chk("reset_rise", ifc.sw_rise, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_out", ifc.sw_out, 3'b000);
    chk("release_rise", ifc.sw_rise, 3'b000);

    // Clean press on ch0
    add(3'b001, 3'b000, 3'b000, 5);
    add(3'b001, 3'b001, 3'b001, 1);
    add(3'b001, 3'b001, 3'b000, 4);
    // 3-cycle low glitch: must not release
    add(3'b000, 3'b001, 3'b000, 3);
    add(3'b001, 3'b001, 3'b000, 6);
    // Clean release
    add(3'b000, 3'b001, 3'b000, 5);
    add(3'b000, 3'b000, 3'b000, 3);
    // Bounce on ch1
    add(3'b010, 3'b000, 3'b000, 1);
    add(3'b000, 3'b000, 3'b000, 1);
    add(3'b010, 3'b000, 3'b000, 2);
    add(3'b000, 3'b000, 3'b000, 7);
    // Simultaneous press on ch0+ch1, then release
    add(3'b011, 3'b000, 3'b000, 5);
    add(3'b011, 3'b011, 3'b011, 1);
    add(3'b011, 3'b011, 3'b000, 2);
    add(3'b000, 3'b011, 3'b000, 5);
    add(3'b000, 3'b000, 3'b000, 2);

    for (int r = 0; r < tbl.size(); r++) begin
      cyc(tbl[r].vin);
      chk($sformatf("tbl%0d_out", r), ifc.sw_out, tbl[r].vout);
      chk($sformatf("tbl%0d_rise", r), ifc.sw_rise, tbl[r].vrise);
    end

    // Reset mid-debounce on ch2 while ch0 is already high
    repeat (7) cyc(3'b001);
    chk("pre_rst_out", ifc.sw_out, 3'b001);
    repeat (2) cyc(3'b101);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_out", ifc.sw_out, 3'b000);
    chk("async_rst_rise", ifc.sw_rise, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rise_cnt = 0;
    rise_idx = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rq_out", ifc.sw_out, m_out);
      chk("rq_rise", ifc.sw_rise, m_rise);
      if (ifc.sw_rise[2]) begin
        rise_cnt++;
        if (rise_idx < 0) rise_idx = i;
      end
    end
    n_chk++;
    if (rise_cnt != 1) begin
      n_fail++;
      $display("FAIL rq_rise_count: got %0d expected 1", rise_cnt);
    end
    n_chk++;
    if (rise_idx != DEB + 1) begin
      n_fail++;
      $display("FAIL rq_rise_edge: got %0d expected %0d", rise_idx, DEB + 1);
    end
    chk("rq_final_out", ifc.sw_out, 3'b101);

    // Randomized: each bit toggles with probability 1/6 per cycle
    v = 3'b000;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(5) == 0) v[b] = ~v[b];
      cyc(v);
      chk("rnd_out", ifc.sw_out, m_out);
      chk("rnd_rise", ifc.sw_rise, m_rise);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
